// File: rtl/dmem_mmio_if.sv
// rtl/dmem_mmio_if.sv - core-side data bus, FIFO drain port and done flags for dmem_mmio
interface dmem_mmio_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  byteEnable;
    logic [31:0] rd;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        done;
    logic [7:0]  done_code;

    modport master (
        output we, a, wd, byteEnable, out_ready,
        input  rd, out_valid, out_data, done, done_code
    );

    modport slave (
        input  we, a, wd, byteEnable, out_ready,
        output rd, out_valid, out_data, done, done_code
    );
endinterface

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - byte-enabled data RAM with an MMIO window (test FIFO, status, cycle counter, done)
module dmem_mmio #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    dmem_mmio_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] fifo_mem [FIFO_DEPTH];

    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycle;
    logic          done_q;
    logic [7:0]    done_code_q;

    logic          mmio_sel;
    logic [7:0]    off;
    logic [AW-1:0] idx;
    logic          ram_we, tx_push, st_wr, cy_wr, dn_wr;
    logic          full, empty, pop, push_ok;
    logic [3:0]    cnt4;
    logic [31:0]   mmio_rd;

    // Page-offset bits above the register decode play no role in either region.
    wire unused_addr = &{1'b0, bus.a[15:8]};

    assign mmio_sel = (bus.a[31:16] == MMIO_HI);
    assign off      = bus.a[7:0];
    assign idx      = bus.a[AW+1:2];

    assign ram_we  = bus.we && !mmio_sel;
    assign tx_push = bus.we && mmio_sel && (off == 8'h00) && (bus.byteEnable == 4'hF);
    assign st_wr   = bus.we && mmio_sel && (off == 8'h04);
    assign cy_wr   = bus.we && mmio_sel && (off == 8'h08);
    assign dn_wr   = bus.we && mmio_sel && (off == 8'h0C);

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && bus.out_ready;
    // A pop frees the slot on the same edge, so a push into a full FIFO still lands.
    assign push_ok = tx_push && (!full || pop);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteEnable[i]) mem[idx][8*i +: 8] <= bus.wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.wd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FW'(1);
            if (pop)     rd_ptr <= rd_ptr + FW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (tx_push && full && !pop)    overflow <= 1'b1;
            else if (st_wr && bus.wd[2])    overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle       <= '0;
            done_q      <= 1'b0;
            done_code_q <= '0;
        end else begin
            cycle <= cy_wr ? bus.wd : cycle + 32'd1;
            if (dn_wr && !done_q) begin
                done_q      <= 1'b1;
                done_code_q <= bus.wd[7:0];
            end
        end
    end

    assign cnt4 = 4'(count);

    always_comb begin
        mmio_rd = '0;
        case (off)
            8'h04:   mmio_rd = {25'b0, cnt4, overflow, full, empty};
            8'h08:   mmio_rd = cycle;
            8'h0C:   mmio_rd = {23'b0, done_q, done_code_q};
            default: mmio_rd = '0;
        endcase
    end

    assign bus.rd        = mmio_sel ? mmio_rd : mem[idx];
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 32'h0 : fifo_mem[rd_ptr];
    assign bus.done      = done_q;
    assign bus.done_code = done_code_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed vector bench for dmem_mmio
module tb_dmem_mmio;
    localparam logic [31:0] TX = 32'hFFFF0000;
    localparam logic [31:0] ST = 32'hFFFF0004;
    localparam logic [31:0] CY = 32'hFFFF0008;
    localparam logic [31:0] DN = 32'hFFFF000C;

    logic clk = 1'b0;
    logic reset;
    dmem_mmio_if bus();

    dmem_mmio #(.DEPTH_WORDS(64), .FIFO_DEPTH(4), .MMIO_HI(16'hFFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

    function automatic void v(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input logic rdy, input logic chk_rd,
                              input logic [31:0] exp_rd, input logic exp_valid,
                              input logic [31:0] exp_data);
        vec_t r;
        r = '{we, a, wd, be, rdy, chk_rd, exp_rd, exp_valid, exp_data};
        vt.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic rdy);
        bus.we = we; bus.a = a; bus.wd = wd; bus.byteEnable = be; bus.out_ready = rdy;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (2) step();
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_data", bus.out_data, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_code", {24'b0, bus.done_code}, 32'h0);
        reset = 1'b0;

        //   we    a             wd            be     rdy   chk   rd            vld   data
        v(1'b1, 32'h10,       32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
        v(1'b1, 32'h10,       32'h11223344, 4'h5, 1'b0, 1'b1, 32'hAABBCCDD, 1'b0, 32'h0);
        v(1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hAA22CC44, 1'b0, 32'h0);
        v(1'b1, 32'h110,      32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'hAA22CC44, 1'b0, 32'h0);
        v(1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        v(1'b1, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        v(1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        v(1'b1, TX,           32'd1,        4'hF, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);
        v(1'b1, TX,           32'd2,        4'hF, 1'b0, 1'b1, 32'h0,        1'b1, 32'd1);
        v(1'b1, TX,           32'd3,        4'hF, 1'b0, 1'b0, 32'h0,        1'b1, 32'd1);
        v(1'b1, TX,           32'd4,        4'hF, 1'b0, 1'b0, 32'h0,        1'b1, 32'd1);
        v(1'b1, TX,           32'd5,        4'hF, 1'b0, 1'b0, 32'h0,        1'b1, 32'd1);
        v(1'b0, ST,           32'h0,        4'h0, 1'b0, 1'b1, 32'h26,       1'b1, 32'd1);
        v(1'b1, TX,           32'd99,       4'h7, 1'b1, 1'b1, 32'h0,        1'b1, 32'd1);
        v(1'b0, ST,           32'h0,        4'h0, 1'b1, 1'b1, 32'h1C,       1'b1, 32'd2);
        v(1'b0, ST,           32'h0,        4'h0, 1'b1, 1'b1, 32'h14,       1'b1, 32'd3);
        v(1'b0, ST,           32'h0,        4'h0, 1'b1, 1'b1, 32'h0C,       1'b1, 32'd4);
        v(1'b0, ST,           32'h0,        4'h0, 1'b0, 1'b1, 32'h05,       1'b0, 32'h0);
        v(1'b1, ST,           32'h4,        4'hF, 1'b0, 1'b1, 32'h05,       1'b0, 32'h0);
        v(1'b0, ST,           32'h0,        4'h0, 1'b0, 1'b1, 32'h01,       1'b0, 32'h0);
        v(1'b1, TX,           32'd10,       4'hF, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);
        v(1'b1, TX,           32'd11,       4'hF, 1'b0, 1'b0, 32'h0,        1'b1, 32'd10);
        v(1'b1, TX,           32'd12,       4'hF, 1'b0, 1'b0, 32'h0,        1'b1, 32'd10);
        v(1'b1, TX,           32'd13,       4'hF, 1'b0, 1'b0, 32'h0,        1'b1, 32'd10);
        v(1'b1, TX,           32'd14,       4'hF, 1'b1, 1'b1, 32'h0,        1'b1, 32'd10);
        v(1'b0, ST,           32'h0,        4'h0, 1'b0, 1'b1, 32'h22,       1'b1, 32'd11);
        v(1'b0, ST,           32'h0,        4'h0, 1'b1, 1'b1, 32'h22,       1'b1, 32'd11);
        v(1'b0, ST,           32'h0,        4'h0, 1'b1, 1'b1, 32'h18,       1'b1, 32'd12);
        v(1'b0, ST,           32'h0,        4'h0, 1'b1, 1'b1, 32'h10,       1'b1, 32'd13);
        v(1'b0, ST,           32'h0,        4'h0, 1'b1, 1'b1, 32'h08,       1'b1, 32'd14);
        v(1'b0, ST,           32'h0,        4'h0, 1'b0, 1'b1, 32'h01,       1'b0, 32'h0);
        v(1'b0, 32'hFFFF0010, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);
        v(1'b1, 32'hFFFF0010, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);
        v(1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        v(1'b0, 32'hFFFF0003, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0);

        foreach (vt[i]) begin
            drive(vt[i].we, vt[i].a, vt[i].wd, vt[i].be, vt[i].rdy);
            #1;
            if (vt[i].chk_rd) check($sformatf("vec%0d_rd", i), bus.rd, vt[i].exp_rd);
            check($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, vt[i].exp_valid});
            check($sformatf("vec%0d_data", i), bus.out_data, vt[i].exp_data);
            step();
        end

        // done register: first write sticks until reset
        drive(1'b1, DN, 32'h1A5, 4'hF, 1'b0);
        step();
        drive(1'b0, DN, 32'h0, 4'h0, 1'b0);
        #1;
        check("done_set", {31'b0, bus.done}, 32'h1);
        check("done_code", {24'b0, bus.done_code}, 32'hA5);
        check("done_rd", bus.rd, 32'h1A5);
        drive(1'b1, DN, 32'h7, 4'hF, 1'b0);
        step();
        drive(1'b0, DN, 32'h0, 4'h0, 1'b0);
        #1;
        check("done_code_hold", {24'b0, bus.done_code}, 32'hA5);
        reset = 1'b1;
        step();
        check("done_rst", {31'b0, bus.done}, 32'h0);
        check("done_code_rst", {24'b0, bus.done_code}, 32'h0);
        reset = 1'b0;

        // cycle counter: 0 in the first cycle out of reset, then load and wrap
        drive(1'b0, CY, 32'h0, 4'h0, 1'b0);
        #1;
        check("cycle0", bus.rd, 32'd0);
        repeat (5) step();
        check("cycle5", bus.rd, 32'd5);
        drive(1'b1, CY, 32'hFFFFFFFE, 4'hF, 1'b0);
        step();
        drive(1'b0, CY, 32'h0, 4'h0, 1'b0);
        #1;
        check("cycle_load", bus.rd, 32'hFFFFFFFE);
        step();
        check("cycle_inc", bus.rd, 32'hFFFFFFFF);
        step();
        check("cycle_wrap", bus.rd, 32'h0);

        // reset with entries queued
        drive(1'b1, TX, 32'h55, 4'hF, 1'b0);
        step();
        drive(1'b1, TX, 32'h66, 4'hF, 1'b0);
        step();
        drive(1'b0, ST, 32'h0, 4'h0, 1'b0);
        #1;
        check("q_valid", {31'b0, bus.out_valid}, 32'h1);
        check("q_data", bus.out_data, 32'h55);
        check("q_status", bus.rd, 32'h10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rst_q_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_q_data", bus.out_data, 32'h0);
        check("rst_q_status", bus.rd, 32'h01);
        drive(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        #1;
        check("ram_retained", bus.rd, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
